// File: rtl/instr_mem_fetch.sv
// Instruction store with a synchronous read port, valid/ready fetch handshake,
// a 2-entry response FIFO, a program-load write port, flush and fault reporting.
module instr_mem_fetch #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [DATA_W-1:0]     load_data,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_instr,
    output logic [ADDR_W-1:0]     resp_addr,
    output logic [1:0]            resp_fault
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     rd_data_reg;

    logic [1:0]            count_reg, count_next;
    logic                  wr_ptr_reg, wr_ptr_next;
    logic                  rd_ptr_reg, rd_ptr_next;
    logic                  pend_reg;
    logic                  pend_ptr_reg;

    logic [DEPTH_LOG2-1:0] req_idx;
    logic [1:0]            req_fault;
    logic                  push;
    logic                  pop;

    logic [1:0][DATA_W-1:0] entry_instr;
    logic [1:0][ADDR_W-1:0] entry_addr;
    logic [1:0][1:0]        entry_fault;
    logic [DATA_W-1:0]      head_instr;

    assign req_idx      = req_addr[DEPTH_LOG2+1:2];
    assign req_fault[0] = (req_addr[1:0] != 2'b00);
    assign req_fault[1] = |req_addr[ADDR_W-1:DEPTH_LOG2+2];

    assign resp_valid = (count_reg != 2'd0);
    assign req_ready  = !reset && !flush && ((count_reg != 2'd2) || resp_ready);
    assign push       = req_valid && req_ready;
    assign pop        = resp_valid && resp_ready && !flush && !reset;

    // Nonblocking write alongside the read gives read-before-write on a collision.
    always_ff @(posedge clk) begin
        if (load_en && !reset) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_data_reg <= mem[req_idx];
        end
    end

    always_comb begin
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush) begin
            count_next  = 2'd0;
            wr_ptr_next = 1'b0;
            rd_ptr_next = 1'b0;
        end else begin
            count_next  = count_reg + {1'b0, push} - {1'b0, pop};
            wr_ptr_next = wr_ptr_reg ^ push;
            rd_ptr_next = rd_ptr_reg ^ pop;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg    <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            pend_reg     <= 1'b0;
            pend_ptr_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            pend_reg     <= push;
            pend_ptr_reg <= wr_ptr_reg;
        end
    end

    // The memory word lands in rd_data_reg one edge after the push, so each
    // entry copies it in the following cycle while the head mux bypasses it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            localparam logic SEL = 1'(gi);
            logic [DATA_W-1:0] instr_reg;
            logic [ADDR_W-1:0] addr_reg;
            logic [1:0]        fault_reg;

            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == SEL)) begin
                    addr_reg  <= req_addr;
                    fault_reg <= req_fault;
                end
                if (pend_reg && (pend_ptr_reg == SEL)) begin
                    instr_reg <= rd_data_reg;
                end
            end

            assign entry_instr[gi] = instr_reg;
            assign entry_addr[gi]  = addr_reg;
            assign entry_fault[gi] = fault_reg;
        end
    endgenerate

    assign head_instr = (pend_reg && (pend_ptr_reg == rd_ptr_reg)) ? rd_data_reg
                                                                  : entry_instr[rd_ptr_reg];

    // Outputs are forced to zero when empty; faulted entries report a nop.
    always_comb begin
        resp_instr = '0;
        resp_addr  = '0;
        resp_fault = 2'b00;
        if (resp_valid) begin
            resp_addr  = entry_addr[rd_ptr_reg];
            resp_fault = entry_fault[rd_ptr_reg];
            if (entry_fault[rd_ptr_reg] == 2'b00) begin
                resp_instr = head_instr;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch: load, streaming, back-pressure, faults,
// load/read collision, flush and reset.
module tb_instr_mem_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [6:0]  load_addr;
    logic [31:0] load_data;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic [31:0] resp_addr;
    logic [1:0]  resp_fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [4] = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};

    instr_mem_fetch #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_instr (resp_instr),
        .resp_addr  (resp_addr),
        .resp_fault (resp_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_resp(input string tag, input logic v, input logic [31:0] ins,
                              input logic [31:0] a, input logic [1:0] f);
        check({tag, ".valid"}, {31'd0, resp_valid}, {31'd0, v});
        check({tag, ".instr"}, resp_instr, ins);
        check({tag, ".addr"},  resp_addr, a);
        check({tag, ".fault"}, {30'd0, resp_fault}, {30'd0, f});
    endtask

    // Advance one edge; inputs change and checks happen in the low phase.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [6:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        cyc();
        load_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        flush = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        #1;
        check_resp("reset", 1'b0, 32'h0, 32'h0, 2'b00);
        check("reset.ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 4; i++) load_word(7'(i), prog[i]);
        load_word(7'd5, 32'h11111111);

        // 1: back-to-back stream, one response per cycle
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_addr = 32'(4 * i);
            #1;
            check("s1.ready", {31'd0, req_ready}, 32'd1);
            if (i == 0) check("s1.lat0", {31'd0, resp_valid}, 32'd0);
            else check_resp("s1.resp", 1'b1, prog[i-1], 32'(4 * (i - 1)), 2'b00);
            cyc();
        end
        req_valid = 1'b0;
        #1;
        check_resp("s1.last", 1'b1, prog[3], 32'hC, 2'b00);
        cyc();
        check("s1.empty", {31'd0, resp_valid}, 32'd0);

        // 2: back-pressure
        resp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        #1; check("s2.rdy0", {31'd0, req_ready}, 32'd1);
        cyc();
        req_addr = 32'h4;
        #1; check("s2.rdy1", {31'd0, req_ready}, 32'd1);
        check_resp("s2.h0", 1'b1, prog[0], 32'h0, 2'b00);
        cyc();
        req_addr = 32'h8;
        #1; check("s2.full", {31'd0, req_ready}, 32'd0);
        check_resp("s2.stall1", 1'b1, prog[0], 32'h0, 2'b00);
        cyc();
        #1; check("s2.full2", {31'd0, req_ready}, 32'd0);
        check_resp("s2.stall2", 1'b1, prog[0], 32'h0, 2'b00);
        resp_ready = 1'b1;
        #1; check("s2.pushpop", {31'd0, req_ready}, 32'd1);
        cyc();
        req_valid = 1'b0;
        #1; check_resp("s2.h1", 1'b1, prog[1], 32'h4, 2'b00);
        cyc();
        check_resp("s2.h2", 1'b1, prog[2], 32'h8, 2'b00);
        cyc();
        check("s2.empty", {31'd0, resp_valid}, 32'd0);

        // 3: faults
        req_valid = 1'b1; req_addr = 32'h6;
        cyc();
        req_addr = 32'h200;
        #1; check_resp("s3.mis", 1'b1, 32'h0, 32'h6, 2'b01);
        cyc();
        req_addr = 32'h202;
        #1; check_resp("s3.range", 1'b1, 32'h0, 32'h200, 2'b10);
        cyc();
        req_valid = 1'b0;
        #1; check_resp("s3.both", 1'b1, 32'h0, 32'h202, 2'b11);
        cyc();

        // 4: load/read collision returns old word
        load_en = 1'b1; load_addr = 7'd5; load_data = 32'h22222222;
        req_valid = 1'b1; req_addr = 32'h14;
        cyc();
        load_en = 1'b0;
        #1; check_resp("s4.old", 1'b1, 32'h11111111, 32'h14, 2'b00);
        cyc();
        req_valid = 1'b0;
        #1; check_resp("s4.new", 1'b1, 32'h22222222, 32'h14, 2'b00);
        cyc();

        // 5: flush with two queued entries
        resp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        cyc();
        req_addr = 32'h4;
        cyc();
        flush = 1'b1; req_addr = 32'h8;
        #1; check("s5.rdy", {31'd0, req_ready}, 32'd0);
        cyc();
        flush = 1'b0; req_valid = 1'b0;
        #1; check("s5.v1", {31'd0, resp_valid}, 32'd0);
        cyc();
        check("s5.v2", {31'd0, resp_valid}, 32'd0);
        resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
        cyc();
        req_valid = 1'b0;
        #1; check_resp("s5.after", 1'b1, prog[1], 32'h4, 2'b00);
        cyc();
        check("s5.empty", {31'd0, resp_valid}, 32'd0);

        // 6: reset with one queued entry and a concurrent load
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
        cyc();
        reset = 1'b1; load_en = 1'b1; load_addr = 7'd0; load_data = 32'hFFFFFFFF;
        req_addr = 32'hC;
        cyc();
        reset = 1'b0; load_en = 1'b0; req_valid = 1'b0;
        #1; check_resp("s6.rst", 1'b0, 32'h0, 32'h0, 2'b00);
        check("s6.ready", {31'd0, req_ready}, 32'd1);
        cyc();
        check("s6.noreq", {31'd0, resp_valid}, 32'd0);
        resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
        cyc();
        req_valid = 1'b0;
        #1; check_resp("s6.word0", 1'b1, prog[0], 32'h0, 2'b00);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
- Parametrised successor to the lab instruction memory: word-organised, byte-addressed instruction store with a synchronous read port.
- Adds a valid/ready fetch handshake, a 2-entry response FIFO for back-pressure, a program-load write port, a flush, and alignment/range fault reporting.
- Sits between the PC/fetch stage and the IF/ID pipeline register; the program is written through the load port before execution.

Parameters:
DATA_W, 32, instruction/word width in bits
ADDR_W, 32, byte-address width of fetch requests
DEPTH_LOG2, 7, log2 of memory depth in words (default 128 words)

Ports:
Clk  in  1  single clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
LoadEn  in  1  write LoadData into memory word LoadAddr this cycle
LoadAddr  in  DEPTH_LOG2  word index for the program-load write
LoadData  in  DATA_W  program word to store
Flush  in  1  discard all queued responses (branch/exception redirect)
ReqValid  in  1  fetch request present
ReqReady  out  1  block can accept a request this cycle
ReqAddr  in  ADDR_W  byte address of the instruction
RespValid  out  1  head response valid
RespReady  in  1  consumer takes head response this cycle
RespInstr  out  DATA_W  fetched instruction (0 on fault)
RespAddr  out  ADDR_W  byte address echoed with the response
RespFault  out  2  00 ok, 01 misaligned (ReqAddr[1:0]!=0), 10 out of range; 11 when both apply

Behaviour:
- Reset (synchronous, sampled at the Clk edge): FIFO emptied. RespValid=0, RespInstr=0, RespAddr=0, RespFault=0. ReqReady=1 in the cycle after Reset deasserts.
  - Memory contents are not cleared.
  - LoadEn and requests presented in a Reset cycle are ignored.
  - Reset mid-operation drops all queued responses.
- Word index = ReqAddr[DEPTH_LOG2+1:2]. Out of range means any of ReqAddr[ADDR_W-1:DEPTH_LOG2+2] is nonzero.
- Accept: ReqValid && ReqReady at an edge.
  - Memory read happens at that edge (synchronous read).
  - The result {instr, addr, fault} is pushed into the FIFO tail.
  - Latency: response is visible on Resp* in the cycle after acceptance if the FIFO was empty. Otherwise it follows strictly in request order.
- Faulted request: still accepted and queued in order, with RespInstr=0 (MIPS nop) and RespFault set. The memory read result is discarded.
- FIFO: 2 entries, occupancy count 0..2. Pop when RespValid && RespReady.
  - ReqReady = (count<2) || RespReady. Simultaneous push+pop at count 2 is legal, and count stays 2.
  - Sustained throughput with RespReady held high: 1 instruction per cycle.
  - RespValid = (count!=0). Resp* outputs are driven from the head entry and hold stable while RespValid && !RespReady.
- Flush (when Reset=0):
  - Count goes to 0 at the edge.
  - ReqReady=0 in the Flush cycle, so no request is accepted and no pop is counted.
  - RespValid=0 from the next cycle.
- Load port: write at the edge when LoadEn && !Reset. A read of the same word at the same edge returns the OLD contents (read-before-write). The new value is visible to requests accepted at later edges. The load port is independent of the handshake and of Flush.
- Pointer wrap: read/write pointers are 1 bit each and wrap 1->0.
- Simultaneous events: Flush overrides push and pop in the same cycle. Reset overrides everything.

Test Plan:
1. Load words 0..3 = 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000; RespReady=1; request 0x0,0x4,0x8,0xC back-to-back.
   -> RespValid on cycles 1..4 with those words, in order, RespFault=00; ReqReady stays 1.
2. Back-pressure: RespReady=0; request 0x0, 0x4, 0x8.
   -> ReqReady drops after 2 accepts; 0x8 held.
   Then RespReady=1 -> 0x20080005, 0x20090003, 0x01095020 in order; RespInstr stable while stalled.
3. Faults: request 0x6 -> RespFault=01, RespInstr=0, RespAddr=0x6.
   Request 0x200 (DEPTH_LOG2=7) -> RespFault=10.
   Request 0x202 -> RespFault=11.
4. Load/read collision: word 5=0x11111111; same edge LoadEn LoadAddr=5 LoadData=0x22222222 and request 0x14.
   -> response 0x11111111; next request 0x14 -> 0x22222222.
5. Flush with 2 queued entries and ReqValid=1.
   -> ReqReady=0 that cycle, RespValid=0 next cycle, no stale response ever appears. Next request 0x4 -> 0x20090003 one cycle later.
6. Reset asserted with FIFO holding 1 entry plus a concurrent load to word 0 of 0xFFFFFFFF.
   -> all outputs 0, ReqReady=1 after release, word 0 still reads 0x20080005.
